// File: rtl/pll_dyn_ctrl_if.sv
// Config and phase-step request port of pll_dyn_ctrl.
// The requester side uses the master modport and the controller uses the slave modport.
interface pll_dyn_ctrl_if #(
   parameter int NUM_OUT = 2
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [9:0]            cfg_idiv;
   logic [9:0]            cfg_fdiv;
   logic [NUM_OUT*10-1:0] cfg_odiv;
   logic [NUM_OUT*10-1:0] cfg_duty;
   logic                  ph_valid;
   logic                  ph_ready;
   logic [2:0]            ph_sel;
   logic                  ph_dir;
   logic [7:0]            ph_steps;

   modport master (
      output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty,
      output ph_valid, ph_sel, ph_dir, ph_steps,
      input  cfg_ready, ph_ready
   );

   modport slave (
      input  cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty,
      input  ph_valid, ph_sel, ph_dir, ph_steps,
      output cfg_ready, ph_ready
   );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// PLL runtime reconfiguration and lock supervisor: sequences PLL reset around ratio
// changes, qualifies LOCK with a glitch filter and timeout, retries, and steps phase.
module pll_dyn_ctrl #(
   parameter int unsigned           NUM_OUT      = 2,
   parameter int unsigned           RST_CYCLES   = 8,
   parameter int unsigned           LOCK_FILTER  = 16,
   parameter int unsigned           LOCK_TIMEOUT = 65535,
   parameter int unsigned           MAX_RETRY    = 3,
   parameter logic [9:0]            INIT_IDIV    = 10'd5,
   parameter logic [9:0]            INIT_FDIV    = 10'd74,
   parameter logic [NUM_OUT*10-1:0] INIT_ODIV    = {10'd74, 10'd5},
   parameter logic [NUM_OUT*10-1:0] INIT_DUTY    = {10'd74, 10'd5}
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   pll_dyn_ctrl_if.slave         cfg_if,
   input  logic                  pll_lock_i,
   output logic                  pll_rst_o,
   output logic                  rstodiv_o,
   output logic [9:0]            dyn_idiv_o,
   output logic [9:0]            dyn_fdiv_o,
   output logic [NUM_OUT*10-1:0] dyn_odiv_o,
   output logic [NUM_OUT*10-1:0] dyn_duty_o,
   output logic [2:0]            phase_sel_o,
   output logic                  phase_dir_o,
   output logic                  phase_step_n_o,
   output logic                  locked_o,
   output logic                  busy_o,
   output logic                  err_o,
   output logic                  lock_lost_o
);
   localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned FW  = $clog2(LOCK_FILTER + 1);
   localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RW  = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {S_INIT, S_RST, S_WAIT, S_FILT, S_RUN, S_PHASE, S_FAIL} state_e;

   state_e                state_q, state_d;
   logic                  lock_meta_q, lock_s_q;
   logic [RCW-1:0]        rcnt_q;
   logic [FW-1:0]         filt_q;
   logic [TW-1:0]         tmo_q;
   logic [RW-1:0]         retry_q;
   logic [7:0]            steps_q;
   logic [1:0]            sub_q;
   logic                  pll_rst_q, rstodiv_q, locked_q, busy_q, err_q, lock_lost_q;
   logic                  phase_dir_q, phase_step_n_q;
   logic [2:0]            phase_sel_q;
   logic [9:0]            dyn_idiv_q, dyn_fdiv_q;
   logic [NUM_OUT*10-1:0] dyn_odiv_q, dyn_duty_q;
   logic                  cfg_acc, ph_acc, tmo_hit, filt_done, timeout, fail_next;

   // Ready is withheld once lock_s drops in RUN so a lock loss never swallows a request.
   assign cfg_if.cfg_ready = (state_q == S_RUN && lock_s_q) || (state_q == S_FAIL);
   assign cfg_if.ph_ready  = (state_q == S_RUN) && lock_s_q && !cfg_if.cfg_valid;
   assign cfg_acc          = cfg_if.cfg_valid && cfg_if.cfg_ready;
   assign ph_acc           = cfg_if.ph_valid && cfg_if.ph_ready;

   always_comb begin
      tmo_hit   = (tmo_q == TW'(LOCK_TIMEOUT - 1));
      filt_done = lock_s_q && (filt_q == FW'(LOCK_FILTER - 1));
      timeout   = tmo_hit && ((state_q == S_WAIT) || (state_q == S_FILT && !filt_done));
      fail_next = !(retry_q < RW'(MAX_RETRY - 1));
      state_d   = state_q;
      case (state_q)
         S_INIT:  state_d = S_RST;
         S_RST:   if (rcnt_q == RCW'(RST_CYCLES - 1)) state_d = S_WAIT;
         S_WAIT: begin
            if (timeout)       state_d = fail_next ? S_FAIL : S_RST;
            else if (lock_s_q) state_d = S_FILT;
         end
         S_FILT: begin
            if (filt_done)      state_d = S_RUN;
            else if (timeout)   state_d = fail_next ? S_FAIL : S_RST;
            else if (!lock_s_q) state_d = S_WAIT;
         end
         S_RUN: begin
            if (!lock_s_q || cfg_acc) state_d = S_RST;
            else if (ph_acc)          state_d = S_PHASE;
         end
         S_PHASE: begin
            if (!lock_s_q)            state_d = S_RST;
            else if (steps_q == '0)   state_d = S_RUN;
         end
         S_FAIL:  if (cfg_acc) state_d = S_RST;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_INIT;
         lock_meta_q    <= 1'b0;
         lock_s_q       <= 1'b0;
         rcnt_q         <= '0;
         filt_q         <= '0;
         tmo_q          <= '0;
         retry_q        <= '0;
         steps_q        <= '0;
         sub_q          <= '0;
         pll_rst_q      <= 1'b1;
         rstodiv_q      <= 1'b1;
         locked_q       <= 1'b0;
         busy_q         <= 1'b1;
         err_q          <= 1'b0;
         lock_lost_q    <= 1'b0;
         phase_sel_q    <= '0;
         phase_dir_q    <= 1'b0;
         phase_step_n_q <= 1'b1;
         dyn_idiv_q     <= INIT_IDIV;
         dyn_fdiv_q     <= INIT_FDIV;
         dyn_odiv_q     <= INIT_ODIV;
         dyn_duty_q     <= INIT_DUTY;
      end else begin
         {lock_s_q, lock_meta_q} <= {lock_meta_q, pll_lock_i};
         state_q     <= state_d;
         pll_rst_q   <= state_d inside {S_INIT, S_RST, S_FAIL};
         rstodiv_q   <= state_d inside {S_INIT, S_RST, S_FAIL};
         locked_q    <= state_d inside {S_RUN, S_PHASE};
         busy_q      <= !(state_d inside {S_RUN, S_FAIL});
         lock_lost_q <= (state_q inside {S_RUN, S_PHASE}) && !lock_s_q;
         rcnt_q      <= (state_q == S_RST && state_d == S_RST) ? rcnt_q + 1'b1 : '0;
         // Timeout spans WAIT<->FILT bounces and only restarts on a fresh reset attempt.
         tmo_q       <= ((state_q inside {S_WAIT, S_FILT}) && (state_d inside {S_WAIT, S_FILT}))
                        ? tmo_q + 1'b1 : '0;
         filt_q      <= (state_q == S_FILT && state_d == S_FILT) ? filt_q + 1'b1 : '0;

         if ((state_q == S_FILT && state_d == S_RUN) || (state_q == S_FAIL && cfg_acc))
            retry_q <= '0;
         else if (timeout)
            retry_q <= retry_q + 1'b1;

         if (state_d == S_FAIL) err_q <= 1'b1;
         else if (cfg_acc)      err_q <= 1'b0;

         if (cfg_acc) begin
            dyn_idiv_q <= cfg_if.cfg_idiv;
            dyn_fdiv_q <= cfg_if.cfg_fdiv;
            dyn_odiv_q <= cfg_if.cfg_odiv;
            dyn_duty_q <= cfg_if.cfg_duty;
         end

         // Each step is one low cycle (sub 0) followed by three high cycles.
         if (ph_acc) begin
            phase_sel_q <= cfg_if.ph_sel;
            phase_dir_q <= cfg_if.ph_dir;
            steps_q     <= cfg_if.ph_steps;
            sub_q       <= '0;
         end else if (state_q == S_PHASE && state_d == S_PHASE) begin
            sub_q <= sub_q + 1'b1;
            if (sub_q == 2'd3) steps_q <= steps_q - 1'b1;
         end
         phase_step_n_q <= !(state_q == S_PHASE && state_d == S_PHASE && sub_q == 2'd0);
      end
   end

   assign pll_rst_o      = pll_rst_q;
   assign rstodiv_o      = rstodiv_q;
   assign dyn_idiv_o     = dyn_idiv_q;
   assign dyn_fdiv_o     = dyn_fdiv_q;
   assign dyn_odiv_o     = dyn_odiv_q;
   assign dyn_duty_o     = dyn_duty_q;
   assign phase_sel_o    = phase_sel_q;
   assign phase_dir_o    = phase_dir_q;
   assign phase_step_n_o = phase_step_n_q;
   assign locked_o       = locked_q;
   assign busy_o         = busy_q;
   assign err_o          = err_q;
   assign lock_lost_o    = lock_lost_q;
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: power-up lock, reconfig, lock glitch, phase stepping,
// lock loss, retry exhaustion to FAIL, and asynchronous reset.
module tb_pll_dyn_ctrl;
   localparam int NO = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_lock = 1'b0;
   always #5 clk = ~clk;

   pll_dyn_ctrl_if #(.NUM_OUT(NO)) cif ();

   logic        pll_rst, rstodiv, phase_dir, phase_step_n, locked, busy, err, lock_lost;
   logic [9:0]  dyn_idiv, dyn_fdiv;
   logic [19:0] dyn_odiv, dyn_duty;
   logic [2:0]  phase_sel;

   pll_dyn_ctrl #(
      .NUM_OUT(NO), .RST_CYCLES(8), .LOCK_FILTER(16), .LOCK_TIMEOUT(100), .MAX_RETRY(3),
      .INIT_IDIV(10'd5), .INIT_FDIV(10'd74),
      .INIT_ODIV({10'd74, 10'd5}), .INIT_DUTY({10'd74, 10'd5})
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_if(cif), .pll_lock_i(pll_lock),
      .pll_rst_o(pll_rst), .rstodiv_o(rstodiv),
      .dyn_idiv_o(dyn_idiv), .dyn_fdiv_o(dyn_fdiv), .dyn_odiv_o(dyn_odiv), .dyn_duty_o(dyn_duty),
      .phase_sel_o(phase_sel), .phase_dir_o(phase_dir), .phase_step_n_o(phase_step_n),
      .locked_o(locked), .busy_o(busy), .err_o(err), .lock_lost_o(lock_lost)
   );

   int checks = 0;
   int failures = 0;
   int e = -1;
   int lows, lost, lost_at, sel_bad, falls, n;
   int pos[8];
   logic prev_rst;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      e++;
      #1;
   endtask

   task automatic wait_locked(input string tag);
      int k = 0;
      while (locked !== 1'b1 && k < 300) begin
         step();
         k++;
      end
      chk_eq(tag, locked, 1);
   endtask

   task automatic send_cfg(input logic [9:0] odiv0);
      cif.cfg_idiv  = 10'd3;
      cif.cfg_fdiv  = 10'd50;
      cif.cfg_odiv  = {10'd74, odiv0};
      cif.cfg_duty  = {10'd30, 10'd20};
      cif.cfg_valid = 1'b1;
      step();
      cif.cfg_valid = 1'b0;
   endtask

   initial begin
      cif.cfg_valid = 1'b0; cif.cfg_idiv = '0; cif.cfg_fdiv = '0;
      cif.cfg_odiv  = '0;   cif.cfg_duty = '0;
      cif.ph_valid  = 1'b0; cif.ph_sel = '0; cif.ph_dir = 1'b0; cif.ph_steps = '0;

      // Reset values
      #23;
      chk_eq("rst_pll_rst", pll_rst, 1);
      chk_eq("rst_rstodiv", rstodiv, 1);
      chk_eq("rst_step_n", phase_step_n, 1);
      chk_eq("rst_phase_sel", phase_sel, 0);
      chk_eq("rst_idiv", dyn_idiv, 5);
      chk_eq("rst_fdiv", dyn_fdiv, 74);
      chk_eq("rst_odiv", dyn_odiv, 75781);
      chk_eq("rst_duty", dyn_duty, 75781);
      chk_eq("rst_locked", locked, 0);
      chk_eq("rst_busy", busy, 1);
      chk_eq("rst_err", err, 0);
      chk_eq("rst_lock_lost", lock_lost, 0);
      chk_eq("rst_cfg_ready", cif.cfg_ready, 0);
      chk_eq("rst_ph_ready", cif.ph_ready, 0);

      // Power-up: pll_rst released at cycle 9, raw lock at cycle 40, locked at cycle 59
      @(negedge clk);
      rst_n = 1'b1;
      while (e < 7) step();
      chk_eq("pu_rst_c8", pll_rst, 1);
      step();
      chk_eq("pu_rst_c9", pll_rst, 0);
      chk_eq("pu_rstodiv_c9", rstodiv, 0);
      while (e < 39) step();
      pll_lock = 1'b1;
      while (e < 57) step();
      chk_eq("pu_locked_c58", locked, 0);
      step();
      chk_eq("pu_locked_c59", locked, 1);
      chk_eq("pu_busy", busy, 0);
      chk_eq("pu_cfg_ready", cif.cfg_ready, 1);
      chk_eq("pu_ph_ready", cif.ph_ready, 1);
      chk_eq("pu_odiv", dyn_odiv, 75781);

      // Reconfig in RUN: odiv0=10
      send_cfg(10'd10);
      chk_eq("cfg_odiv0", dyn_odiv[9:0], 10);
      chk_eq("cfg_idiv", dyn_idiv, 3);
      chk_eq("cfg_fdiv", dyn_fdiv, 50);
      chk_eq("cfg_duty", dyn_duty, 30740);
      chk_eq("cfg_pll_rst", pll_rst, 1);
      chk_eq("cfg_locked", locked, 0);
      chk_eq("cfg_busy", busy, 1);
      repeat (7) step();
      chk_eq("cfg_rst_k7", pll_rst, 1);
      step();
      chk_eq("cfg_rst_k8", pll_rst, 0);
      repeat (16) step();
      chk_eq("cfg_locked_k24", locked, 0);
      step();
      chk_eq("cfg_locked_k25", locked, 1);

      // One-cycle lock glitch during FILT restarts the filter
      send_cfg(10'd7);
      repeat (14) step();
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      repeat (18) step();
      chk_eq("glitch_locked_k33", locked, 0);
      step();
      chk_eq("glitch_locked_k34", locked, 1);
      chk_eq("glitch_err", err, 0);

      // Concurrent cfg and phase request: cfg first, phase stays pending
      cif.cfg_odiv  = {10'd74, 10'd8};
      cif.cfg_valid = 1'b1;
      cif.ph_valid  = 1'b1; cif.ph_sel = 3'd1; cif.ph_dir = 1'b1; cif.ph_steps = 8'd3;
      #1;
      chk_eq("both_ph_ready", cif.ph_ready, 0);
      chk_eq("both_cfg_ready", cif.cfg_ready, 1);
      step();
      cif.cfg_valid = 1'b0;
      chk_eq("both_cfg_first", dyn_odiv[9:0], 8);
      chk_eq("both_sel_held", phase_sel, 0);
      chk_eq("both_pll_rst", pll_rst, 1);
      n = 0;
      while (cif.ph_ready !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk_eq("ph_pending_ready", cif.ph_ready, 1);
      step();
      cif.ph_valid = 1'b0;
      lows = 0; sel_bad = 0;
      for (int r = 1; r <= 14; r++) begin
         step();
         if (!phase_step_n) begin
            if (lows < 8) pos[lows] = r;
            lows++;
         end
         if (phase_sel != 3'd1) sel_bad++;
         if (r == 3) chk_eq("ph_busy", busy, 1);
         if (r == 12) chk_eq("ph_ready_r12", cif.ph_ready, 0);
         if (r == 13) chk_eq("ph_ready_r13", cif.ph_ready, 1);
      end
      chk_eq("ph_pulses", lows, 3);
      chk_eq("ph_pos0", pos[0], 1);
      chk_eq("ph_pos1", pos[1], 5);
      chk_eq("ph_pos2", pos[2], 9);
      chk_eq("ph_sel_stable", sel_bad, 0);
      chk_eq("ph_dir", phase_dir, 1);

      // Lock loss in RUN
      pll_lock = 1'b0;
      step(); step();
      chk_eq("ll_run_j2", lock_lost, 0);
      step();
      chk_eq("ll_run_j3", lock_lost, 1);
      chk_eq("ll_run_locked", locked, 0);
      chk_eq("ll_run_pll_rst", pll_rst, 1);
      step();
      chk_eq("ll_run_j4", lock_lost, 0);
      pll_lock = 1'b1;
      wait_locked("ll_run_relock");

      // Lock loss during PHASE aborts remaining steps
      cif.ph_sel = 3'd2; cif.ph_dir = 1'b0; cif.ph_steps = 8'd5; cif.ph_valid = 1'b1;
      step();
      cif.ph_valid = 1'b0;
      lows = 0; lost = 0; lost_at = 0;
      for (int r = 1; r <= 20; r++) begin
         step();
         if (!phase_step_n) lows++;
         if (lock_lost) begin
            lost++;
            lost_at = r;
         end
         if (r == 5) chk_eq("llph_sel", phase_sel, 2);
         if (r == 6) pll_lock = 1'b0;
         if (r == 12) pll_lock = 1'b1;
      end
      chk_eq("llph_pulses", lows, 2);
      chk_eq("llph_lost_cnt", lost, 1);
      chk_eq("llph_lost_at", lost_at, 9);
      wait_locked("llph_relock");

      // Lock never returns: three reset attempts then FAIL
      send_cfg(10'd9);
      pll_lock = 1'b0;
      falls = 0;
      prev_rst = pll_rst;
      for (int k = 1; k <= 323; k++) begin
         step();
         if (prev_rst && !pll_rst) falls++;
         prev_rst = pll_rst;
      end
      chk_eq("fail_err_k323", err, 0);
      step();
      chk_eq("fail_err_k324", err, 1);
      chk_eq("fail_rst_pulses", falls, 3);
      chk_eq("fail_pll_rst", pll_rst, 1);
      chk_eq("fail_cfg_ready", cif.cfg_ready, 1);
      chk_eq("fail_locked", locked, 0);
      cif.ph_valid = 1'b1;
      #1;
      chk_eq("fail_ph_ready", cif.ph_ready, 0);
      cif.ph_valid = 1'b0;

      // New cfg leaves FAIL
      pll_lock = 1'b1;
      send_cfg(10'd11);
      chk_eq("fail_cfg_err", err, 0);
      chk_eq("fail_cfg_odiv", dyn_odiv[9:0], 11);
      chk_eq("fail_cfg_pll_rst", pll_rst, 1);
      wait_locked("fail_relock");

      // Asynchronous reset mid-PHASE
      cif.ph_sel = 3'd3; cif.ph_dir = 1'b1; cif.ph_steps = 8'd4; cif.ph_valid = 1'b1;
      step();
      cif.ph_valid = 1'b0;
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_pll_rst", pll_rst, 1);
      chk_eq("arst_step_n", phase_step_n, 1);
      chk_eq("arst_phase_sel", phase_sel, 0);
      chk_eq("arst_phase_dir", phase_dir, 0);
      chk_eq("arst_odiv", dyn_odiv, 75781);
      chk_eq("arst_idiv", dyn_idiv, 5);
      chk_eq("arst_locked", locked, 0);
      chk_eq("arst_busy", busy, 1);
      chk_eq("arst_cfg_ready", cif.cfg_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_locked("arst_relock");
      chk_eq("arst_sel_discarded", phase_sel, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
